// File: rtl/axi_aw_burst_slave_pkg.sv
// axi_pkg: shared AW command types and beat-address helpers for axi_aw_burst_slave.
package axi_pkg;
  localparam int AXI_ID_W = 12;
  localparam int AXI_ADDR_W = 32;
  typedef logic [AXI_ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2, RSVD = 2'd3} burst_t;
  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    addr_t               addr;
    logic [3:0]          len;
    logic [2:0]          size;
    burst_t              burst;
    logic [12:0]         attr;
  } aw_cmd_t;
  function automatic addr_t beat_step(input logic [2:0] size);
    return addr_t'(1) << size;
  endfunction
  function automatic addr_t align_addr(input addr_t a, input logic [2:0] size);
    return a & ~(beat_step(size) - addr_t'(1));
  endfunction
  // (len+1)*2^size - 1, valid because legal wrap lengths make len+1 a power of two
  function automatic addr_t wrap_mask(input logic [3:0] len, input logic [2:0] size);
    return (addr_t'(len) << size) | (beat_step(size) - addr_t'(1));
  endfunction
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return len inside {4'd1, 4'd3, 4'd7, 4'd15};
  endfunction
endpackage

// File: rtl/axi_aw_burst_slave_if.sv
// axi_aw_burst_slave_if: AW channel plus per-beat address stream bundle.
interface axi_aw_burst_slave_if #(
  parameter int ID_MAX_WIDTH = 12,
  parameter int ADDR_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ID_MAX_WIDTH-1:0] awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [3:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [1:0]              awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    beat_valid;
  logic                    beat_ready;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic [ID_MAX_WIDTH-1:0] beat_id;
  logic [3:0]              beat_idx;
  logic                    beat_last;
  logic [12:0]             beat_attr;
  logic                    burst_err;
  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, beat_ready,
    output awready, beat_valid, beat_addr, beat_id, beat_idx, beat_last, beat_attr, burst_err
  );
  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, beat_ready,
    input  awready, beat_valid, beat_addr, beat_id, beat_idx, beat_last, beat_attr, burst_err
  );
endinterface

// File: rtl/axi_aw_burst_slave_cmd_fifo.sv
// axi_cmd_fifo: synchronous FIFO of aw_cmd_t; full/empty come from the registered count only.
module axi_cmd_fifo import axi_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_push,
  input  aw_cmd_t i_data,
  input  logic    i_pop,
  output aw_cmd_t o_data,
  output logic    o_full,
  output logic    o_empty
);
  localparam int PW = $clog2(DEPTH);
  aw_cmd_t       r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0]   r_cnt;
  logic          w_push, w_pop;
  assign o_full = r_cnt == (PW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_data = r_mem[r_rd];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  always_ff @(posedge clk) if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/axi_aw_burst_slave.sv
// axi_aw_burst_slave: AW responder expanding queued commands into per-beat addresses.
// Define AXI_AW_WRAP_EN to generate WRAP bursts; otherwise WRAP is flagged illegal and run as INCR.
module axi_aw_burst_slave import axi_pkg::*; #(
  parameter int ID_MAX_WIDTH = 12,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 8,
  parameter int CMD_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  axi_aw_burst_slave_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_BYTES));
  aw_cmd_t             w_push_cmd, w_head;
  logic                w_full, w_empty, w_pop, w_fire, w_last, w_err, w_wrap_ok, w_valid;
  logic [2:0]          w_size;
  burst_t              w_burst;
  addr_t               w_inc, w_next;
  logic [0:0]          r_state;
  addr_t               r_addr;
  logic [AXI_ID_W-1:0] r_id;
  logic [3:0]          r_idx, r_len;
  logic [2:0]          r_size;
  burst_t              r_burst;
  logic [12:0]         r_attr;
  logic                r_err;
  assign w_push_cmd = '{
    id:    AXI_ID_W'(bus.awid),
    addr:  AXI_ADDR_W'(bus.awaddr),
    len:   bus.awlen,
    size:  bus.awsize,
    burst: burst_t'(bus.awburst),
    attr:  {bus.awlock, bus.awcache, bus.awprot, bus.awqos}
  };
  axi_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (bus.awvalid && bus.awready),
    .i_data  (w_push_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_comb begin
    w_valid = r_state == S_BURST;
    w_fire = w_valid && bus.beat_ready;
    w_last = r_idx == r_len;
    w_pop = !w_empty && (!w_valid || (w_fire && w_last));
`ifdef AXI_AW_WRAP_EN
    w_wrap_ok = w_head.burst == WRAP && wrap_len_ok(w_head.len);
`else
    w_wrap_ok = 1'b0;
`endif
    w_size = w_head.size > MAX_SIZE ? MAX_SIZE : w_head.size;
    w_burst = w_head.burst == FIXED ? FIXED : w_wrap_ok ? WRAP : INCR;
    w_err = w_head.burst == RSVD || (w_head.burst == WRAP && !w_wrap_ok) || w_head.size > MAX_SIZE;
    w_inc = align_addr(r_addr, r_size) + beat_step(r_size);
`ifdef AXI_AW_WRAP_EN
    w_next = r_burst == FIXED ? r_addr :
             r_burst == WRAP  ? (r_addr & ~wrap_mask(r_len, r_size)) | (w_inc & wrap_mask(r_len, r_size)) :
             w_inc;
`else
    w_next = r_burst == FIXED ? r_addr : w_inc;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr <= '0;
      r_id <= '0;
      r_idx <= '0;
      r_len <= '0;
      r_size <= '0;
      r_burst <= FIXED;
      r_attr <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_pop && w_err;
      if (w_pop) begin
        r_state <= S_BURST;
        r_addr <= w_head.addr;
        r_id <= w_head.id;
        r_idx <= '0;
        r_len <= w_head.len;
        r_size <= w_size;
        r_burst <= w_burst;
        r_attr <= w_head.attr;
      end else if (w_fire) begin
        r_state <= w_last ? S_IDLE : S_BURST;
        if (!w_last) begin
          r_idx <= r_idx + 4'd1;
          r_addr <= w_next;
        end
      end
    end
  end
  // full is taken from the registered count, so a pop in the same cycle never reopens awready
  assign bus.awready = rst_n && !w_full;
  assign bus.beat_valid = w_valid;
  assign bus.beat_addr = ADDR_WIDTH'(r_addr);
  assign bus.beat_id = ID_MAX_WIDTH'(r_id);
  assign bus.beat_idx = r_idx;
  assign bus.beat_last = w_valid && w_last;
  assign bus.beat_attr = r_attr;
  assign bus.burst_err = r_err;
endmodule

// File: tb/tb_axi_aw_burst_slave.sv
// tb_axi_aw_burst_slave: directed self-checking bench for axi_aw_burst_slave.
module tb_axi_aw_burst_slave;
  localparam logic [12:0] ATTR = 13'b01_1010_101_0011;
  logic clk;
  logic rst_n;
  int n_chk;
  int n_fail;
  logic [31:0] exp_q[$];
  axi_aw_burst_slave_if #(.ID_MAX_WIDTH(12), .ADDR_WIDTH(32)) bus ();
  axi_aw_burst_slave #(.ID_MAX_WIDTH(12), .ADDR_WIDTH(32), .DATA_BYTES(8), .CMD_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
    int t;
    t = 0;
    bus.awid = id;
    bus.awaddr = addr;
    bus.awlen = len;
    bus.awsize = size;
    bus.awburst = burst;
    bus.awvalid = 1'b1;
    while (!bus.awready && t < 50) begin
      step();
      t++;
    end
    chk("awready_wait", bus.awready, 1);
    step();
    bus.awvalid = 1'b0;
  endtask
  task automatic expect_beats(input logic [11:0] id, input logic err, input bit stall);
    for (int k = 0; k < exp_q.size(); k++) begin
      int t;
      t = 0;
      while (!bus.beat_valid && t < 20) begin
        step();
        t++;
      end
      chk("beat_valid", bus.beat_valid, 1);
      chk("beat_addr", bus.beat_addr, exp_q[k]);
      chk("beat_idx", bus.beat_idx, k);
      chk("beat_last", bus.beat_last, k == exp_q.size() - 1);
      chk("beat_id", bus.beat_id, id);
      chk("beat_attr", bus.beat_attr, ATTR);
      chk("burst_err", bus.burst_err, k == 0 ? err : 1'b0);
      if (stall) begin
        bus.beat_ready = 1'b0;
        step();
        chk("stall_valid", bus.beat_valid, 1);
        chk("stall_addr", bus.beat_addr, exp_q[k]);
        chk("stall_idx", bus.beat_idx, k);
        bus.beat_ready = 1'b1;
      end
      step();
    end
    chk("burst_done", bus.beat_valid, 0);
  endtask
  initial begin
    int t;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.awvalid = 1'b0;
    bus.awid = '0;
    bus.awaddr = '0;
    bus.awlen = '0;
    bus.awsize = '0;
    bus.awburst = '0;
    bus.awlock = 2'b01;
    bus.awcache = 4'hA;
    bus.awprot = 3'b101;
    bus.awqos = 4'h3;
    bus.beat_ready = 1'b1;
    step();
    step();
    chk("rst_awready", bus.awready, 0);
    chk("rst_valid", bus.beat_valid, 0);
    chk("rst_addr", bus.beat_addr, 0);
    chk("rst_id", bus.beat_id, 0);
    chk("rst_idx", bus.beat_idx, 0);
    chk("rst_last", bus.beat_last, 0);
    chk("rst_err", bus.burst_err, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_awready", bus.awready, 1);
    // INCR with unaligned start and two-cycle load latency
    send(12'd1, 32'h1003, 4'd3, 3'd2, 2'd1);
    chk("lat_t1", bus.beat_valid, 0);
    step();
    chk("lat_t2", bus.beat_valid, 1);
    exp_q = '{32'h1003, 32'h1004, 32'h1008, 32'h100C};
    expect_beats(12'd1, 1'b0, 1'b0);
    // WRAP
    send(12'd2, 32'h38, 4'd3, 3'd3, 2'd2);
`ifdef AXI_AW_WRAP_EN
    exp_q = '{32'h38, 32'h20, 32'h28, 32'h30};
    expect_beats(12'd2, 1'b0, 1'b0);
`else
    exp_q = '{32'h38, 32'h40, 32'h48, 32'h50};
    expect_beats(12'd2, 1'b1, 1'b0);
`endif
    // FIXED with consumer stalling every other cycle
    send(12'd3, 32'h200, 4'd15, 3'd2, 2'd0);
    exp_q = {};
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h200);
    expect_beats(12'd3, 1'b0, 1'b1);
    // reserved burst with oversize awsize: clamp to 8-byte stride
    send(12'd7, 32'h101, 4'd2, 3'd7, 2'd3);
    exp_q = '{32'h101, 32'h108, 32'h110};
    expect_beats(12'd7, 1'b1, 1'b0);
    // WRAP with illegal length is always run as INCR
    send(12'd8, 32'h10, 4'd2, 3'd2, 2'd2);
    exp_q = '{32'h10, 32'h14, 32'h18};
    expect_beats(12'd8, 1'b1, 1'b0);
    // three back-to-back bursts
    bus.awid = 12'd4;
    bus.awaddr = 32'h1000;
    bus.awlen = 4'd1;
    bus.awsize = 3'd3;
    bus.awburst = 2'd1;
    bus.awvalid = 1'b1;
    chk("b2b_rdy0", bus.awready, 1);
    step();
    bus.awid = 12'd5;
    bus.awaddr = 32'h2000;
    chk("b2b_rdy1", bus.awready, 1);
    step();
    chk("b2b_a0_valid", bus.beat_valid, 1);
    chk("b2b_a0_id", bus.beat_id, 4);
    chk("b2b_a0_addr", bus.beat_addr, 32'h1000);
    chk("b2b_rdy2", bus.awready, 1);
    bus.awid = 12'd6;
    bus.awaddr = 32'h3000;
    bus.awlen = 4'd0;
    step();
    chk("b2b_full", bus.awready, 0);
    chk("b2b_a1_addr", bus.beat_addr, 32'h1008);
    chk("b2b_a1_last", bus.beat_last, 1);
    bus.awvalid = 1'b0;
    step();
    chk("b2b_b0_valid", bus.beat_valid, 1);
    chk("b2b_b0_id", bus.beat_id, 5);
    chk("b2b_b0_addr", bus.beat_addr, 32'h2000);
    chk("b2b_b0_idx", bus.beat_idx, 0);
    chk("b2b_rdy3", bus.awready, 1);
    step();
    chk("b2b_b1_addr", bus.beat_addr, 32'h2008);
    chk("b2b_b1_last", bus.beat_last, 1);
    step();
    chk("b2b_c0_valid", bus.beat_valid, 1);
    chk("b2b_c0_id", bus.beat_id, 6);
    chk("b2b_c0_addr", bus.beat_addr, 32'h3000);
    chk("b2b_c0_last", bus.beat_last, 1);
    step();
    chk("b2b_done", bus.beat_valid, 0);
    // reset mid-burst with a second command still queued
    bus.beat_ready = 1'b0;
    send(12'd9, 32'h0, 4'd7, 3'd2, 2'd1);
    send(12'd10, 32'h500, 4'd0, 3'd2, 2'd1);
    bus.beat_ready = 1'b1;
    t = 0;
    while (bus.beat_idx != 4'd5 && t < 20) begin
      step();
      t++;
    end
    chk("pre_rst_idx", bus.beat_idx, 5);
    chk("pre_rst_addr", bus.beat_addr, 32'h14);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", bus.beat_valid, 0);
    chk("mid_rst_idx", bus.beat_idx, 0);
    chk("mid_rst_addr", bus.beat_addr, 0);
    chk("mid_rst_awready", bus.awready, 0);
    rst_n = 1'b1;
    step();
    chk("rel_awready", bus.awready, 1);
    chk("rel_valid", bus.beat_valid, 0);
    step();
    chk("fifo_flushed", bus.beat_valid, 0);
    send(12'd11, 32'h40, 4'd1, 3'd2, 2'd1);
    exp_q = '{32'h40, 32'h44};
    expect_beats(12'd11, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_aw_burst_slave.md
# axi_aw_burst_slave

Slave (responder) end of the AXI3-style write address channel. Accepts AW handshakes from an upstream master, buffers commands in a small FIFO, and expands each command into a per-beat address stream (FIXED/INCR/WRAP) that the write-data/memory side consumes beat by beat. Sits between the AXI bus fabric and the accelerator's on-chip buffer write port.

## Interface
- ID_MAX_WIDTH, 12, AW ID width
- ADDR_WIDTH, 32, address width
- DATA_BYTES, 8, data bus width in bytes (power of 2, 1..128)
- CMD_DEPTH, 2, command FIFO depth (power of 2, >=2)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- awid  in  ID_MAX_WIDTH  transaction ID
- awaddr  in  ADDR_WIDTH  start address
- awlen  in  4  beats minus one
- awsize  in  3  log2 bytes per beat
- awburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- awlock, awcache, awprot, awqos  in  2/4/3/4  captured, forwarded on beat_attr
- beat_valid  out  1  beat address valid
- beat_ready  in  1  consumer accepts beat
- beat_addr  out  ADDR_WIDTH  address of current beat
- beat_id  out  ID_MAX_WIDTH  awid of owning burst
- beat_idx  out  4  beat number, 0..awlen
- beat_last  out  1  final beat of burst
- beat_attr  out  13  {awlock,awcache,awprot,awqos}
- burst_err  out  1  one-cycle pulse at command load on illegal command

## Operation
- awready = FIFO not full; push on awvalid && awready.
- FSM IDLE / BURST. IDLE: FIFO non-empty -> pop, load generator, go BURST. BURST: beat handshake advances idx/addr; on beat_last handshake pop next command if FIFO non-empty (stay BURST), else IDLE.
- Address: beat 0 = awaddr unmodified. FIXED: all beats = awaddr. INCR: beat n>0 = align(awaddr, 2^awsize) + n*2^awsize, ADDR_WIDTH wrap-around. WRAP: wrap size W = (awlen+1)*2^awsize; lower = awaddr & ~(W-1); next addr = aligned+2^awsize, reset to lower on reaching lower+W.
- 4 KB boundary not checked.
- Illegal (burst_err pulse, command still executed): awburst=3 (run as INCR); WRAP with awlen not in {1,3,7,15} (run as INCR); awsize > log2(DATA_BYTES) (clamp to log2(DATA_BYTES)).
- beat_* fields stable while beat_valid && !beat_ready.

## Timing
- Reset: awready 0 during reset, 1 first cycle after; beat_valid 0, beat_addr 0, beat_id 0, beat_idx 0, beat_last 0, burst_err 0; FIFO empty, FSM IDLE.
- Latency: AW handshake at edge T -> beat_valid high from edge T+2 (push T, pop/load T+1).
- Back-to-back: last beat of burst k and first beat of burst k+1 with no bubble when k+1 already queued.
- Simultaneous push and pop on full FIFO: awready remains 0 (full is registered before pop); no bypass.
- awlen=0: single beat, beat_last=1 at idx 0.
- Reset asserted mid-burst: all state and queued commands discarded at next edge.

## Configuration
- AXI_AW_WRAP_EN defined: WRAP bursts generated as above.
- Not defined: WRAP logic omitted; awburst=2 treated as illegal (burst_err pulse, run as INCR).

## Structure
- Package axi_pkg: burst_t enum (FIXED/INCR/WRAP/RSVD), aw_cmd_t struct {id,addr,len,size,burst,attr}, beat-address helper functions.
- Sub-module axi_cmd_fifo: parameterized synchronous FIFO of aw_cmd_t (push/pop/full/empty).

## Test plan
- INCR awaddr=0x1003, awlen=3, awsize=2 -> beat_addr 0x1003,0x1004,0x1008,0x100C; beat_last on idx 3; first beat_valid 2 cycles after handshake.
- WRAP awaddr=0x38, awlen=3, awsize=3 -> 0x38,0x20,0x28,0x30; without AXI_AW_WRAP_EN -> burst_err pulse, 0x38,0x40,0x48,0x50.
- FIXED awaddr=0x200, awlen=15 with beat_ready toggling every cycle -> 16 beats all 0x200, fields stable during stalls.
- Three bursts issued back-to-back, beat_ready=1 -> awready drops when 2 queued, no bubble between bursts, IDs in order.
- awburst=3, awsize=7 with DATA_BYTES=8 -> burst_err single pulse, INCR with 8-byte stride.
- rst_n low mid-burst (idx 5 of 8) -> next cycle beat_valid 0, FIFO empty, awready 1 after release, new burst starts at idx 0.
